// File: rtl/run_seq_pkg.sv
// Shared types for the run sequencer: the FSM state encoding and the packed
// response record handed back to the host harness.
package run_seq_pkg;

  localparam int PW_DEF = 2;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRST   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4
  } run_state_t;

  typedef struct packed {
    logic [PW_DEF-1:0] prog;
    logic [CW_DEF-1:0] cycles;
    logic              timeout;
    logic              err;
  } run_rsp_t;

endpackage

// File: rtl/run_sequencer_cycle_counter.sv
// Saturating up-counter with synchronous clear; hit flags that the count
// about to be reached on this edge (count+1) equals LIMIT.
module cycle_counter #(
  parameter int            CW    = 16,
  parameter logic [CW-1:0] LIMIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          hit
);

  logic [CW:0] count_plus;

  // Extra bit keeps the comparison honest once the count sits at all-ones.
  assign count_plus = {1'b0, count} + {{CW{1'b0}}, 1'b1};
  assign hit        = (count_plus == {1'b0, LIMIT});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count_plus[CW-1:0];
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Launch controller for the CPU core: resets it, holds start for a setup
// window, times the run until done or timeout, and returns one result record.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NPROG        = 3,
  parameter int PW           = 2,
  parameter int CW           = 16,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [PW-1:0] req_prog,
  output logic          cpu_reset,
  output logic          cpu_start,
  output logic [PW-1:0] cpu_prog,
  input  logic          cpu_done,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [PW-1:0] rsp_prog,
  output logic [CW-1:0] rsp_cycles,
  output logic          rsp_timeout,
  output logic          rsp_err
);

  localparam logic [PW:0]   NPROG_W     = (PW+1)'(NPROG);
  localparam logic [CW-1:0] START_LIM   = CW'(START_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT);

  run_state_t    state, next_state;
  logic [CW-1:0] start_count_unused;
  logic [CW-1:0] run_count, run_next;
  logic          start_hit, run_hit;
  logic          accept, bad_prog;

  assign accept   = (state == IDLE) && req_valid;
  assign bad_prog = ({1'b0, req_prog} >= NPROG_W);
  assign run_next = (&run_count) ? run_count : run_count + {{(CW-1){1'b0}}, 1'b1};

  cycle_counter #(.CW(CW), .LIMIT(START_LIM)) start_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state != START),
    .en    (state == START),
    .count (start_count_unused),
    .hit   (start_hit)
  );

  cycle_counter #(.CW(CW), .LIMIT(TIMEOUT_LIM)) run_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state != RUN),
    .en    (state == RUN),
    .count (run_count),
    .hit   (run_hit)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = bad_prog ? REPORT : CRST;
      CRST:    next_state = START;
      START:   if (start_hit) next_state = RUN;
      RUN:     if (cpu_done || run_hit) next_state = REPORT;
      REPORT:  if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      cpu_reset <= 1'b1;
      cpu_start <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == IDLE);
      cpu_reset <= (next_state == IDLE) || (next_state == CRST);
      cpu_start <= (next_state == START);
      rsp_valid <= (next_state == REPORT);
    end
  end

  // Done takes priority over the timeout when both land on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_prog    <= '0;
      rsp_prog    <= '0;
      rsp_cycles  <= '0;
      rsp_timeout <= 1'b0;
      rsp_err     <= 1'b0;
    end else if (accept) begin
      cpu_prog    <= req_prog;
      rsp_prog    <= req_prog;
      rsp_cycles  <= '0;
      rsp_timeout <= 1'b0;
      rsp_err     <= bad_prog;
    end else if (state == RUN) begin
      if (cpu_done) begin
        rsp_cycles <= run_next;
      end else if (run_hit) begin
        rsp_cycles  <= TIMEOUT_LIM;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomised bench for run_sequencer: a timeline-based model predicts every
// output each cycle, and a few directed runs pin the model with literal values.
`timescale 1ns/1ps
module tb_run_sequencer;
  import run_seq_pkg::*;

  localparam int SC = 2;
  localparam int TO = 100;
  localparam int NP = 3;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_REP  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_prog = 2'd0;
  logic        cpu_reset;
  logic        cpu_start;
  logic [1:0]  cpu_prog;
  logic        cpu_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_prog;
  logic [15:0] rsp_cycles;
  logic        rsp_timeout;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  int       m_phase = P_IDLE;
  int       m_d = 0;
  run_rsp_t m_rec = '0;
  logic [1:0] m_cpu_prog = 2'd0;

  int       cap_lat, cap_start;
  run_rsp_t cap;

  run_sequencer #(
    .NPROG(NP), .PW(2), .CW(16), .START_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_prog(req_prog),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start), .cpu_prog(cpu_prog),
    .cpu_done(cpu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prog(rsp_prog),
    .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, expressed as a timeline: m_d counts edges since the accept edge.
  task automatic model_edge();
    int j;
    case (m_phase)
      P_IDLE: if (req_valid) begin
        m_cpu_prog    = req_prog;
        m_rec.prog    = req_prog;
        m_rec.cycles  = 16'd0;
        m_rec.timeout = 1'b0;
        m_rec.err     = (int'(req_prog) >= NP);
        m_d           = 0;
        m_phase       = m_rec.err ? P_REP : P_BUSY;
      end
      P_BUSY: begin
        m_d++;
        j = m_d - (SC + 1);
        if (j >= 1) begin
          if (cpu_done) begin
            m_rec.cycles = 16'(j);
            m_phase      = P_REP;
          end else if (j == TO) begin
            m_rec.cycles  = 16'(TO);
            m_rec.timeout = 1'b1;
            m_phase       = P_REP;
          end
        end
      end
      default: if (rsp_ready) m_phase = P_IDLE;
    endcase
  endtask

  task automatic compare_all();
    bit busy;
    busy = (m_phase == P_BUSY);
    check_output("req_ready", req_ready, m_phase == P_IDLE);
    check_output("cpu_reset", cpu_reset, (m_phase == P_IDLE) || (busy && m_d == 0));
    check_output("cpu_start", cpu_start, busy && m_d >= 1 && m_d <= SC);
    check_output("rsp_valid", rsp_valid, m_phase == P_REP);
    check_output("cpu_prog", cpu_prog, m_cpu_prog);
    check_output("rsp_prog", rsp_prog, m_rec.prog);
    check_output("rsp_cycles", rsp_cycles, m_rec.cycles);
    check_output("rsp_timeout", rsp_timeout, m_rec.timeout);
    check_output("rsp_err", rsp_err, m_rec.err);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      if (!reset) begin
        m_phase    = P_IDLE;
        m_rec      = '0;
        m_cpu_prog = 2'd0;
      end
      compare_all();
    end
  end

  // One request: done_j is the RUN edge where done is first seen (0 = never),
  // stale raises done already during the setup window, hold delays rsp_ready.
  task automatic apply_stimulus(input logic [1:0] prog, input int done_j,
                                input bit stale, input int hold);
    bit got;
    got       = 1'b0;
    cap_start = 0;
    cap_lat   = -1;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_prog  = prog;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int d = 0; d < SC + TO + 8; d++) begin
      if (rsp_valid) begin
        got     = 1'b1;
        cap_lat = d;
        break;
      end
      if (cpu_start) cap_start++;
      if (stale && d == 0) cpu_done = 1'b1;
      if (done_j > 0 && d == SC + done_j) cpu_done = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) check_output("rsp_wait_expired", 0, 1);
    cap.prog    = rsp_prog;
    cap.cycles  = rsp_cycles;
    cap.timeout = rsp_timeout;
    cap.err     = rsp_err;
    if (hold > 0) begin
      repeat (hold) begin
        req_valid = 1'b1;
        req_prog  = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cpu_done  = 1'b0;
  endtask

  task automatic reset_mid_run();
    req_valid = 1'b1;
    req_prog  = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (SC + 10) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check_output("abort_cpu_start", cpu_start, 0);
    check_output("abort_cpu_reset", cpu_reset, 1);
    check_output("abort_rsp_valid", rsp_valid, 0);
    check_output("abort_req_ready", req_ready, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_cpu_reset", cpu_reset, 1);
    check_output("rst_cpu_start", cpu_start, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_cycles", rsp_cycles, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(2'd1, 40, 1'b0, 10);
    check_output("t1_cycles", cap.cycles, 40);
    check_output("t1_timeout", cap.timeout, 0);
    check_output("t1_err", cap.err, 0);
    check_output("t1_prog", cap.prog, 1);
    check_output("t1_start_width", cap_start, 2);
    check_output("t1_latency", cap_lat, 43);

    apply_stimulus(2'd3, 0, 1'b0, 0);
    check_output("err_flag", cap.err, 1);
    check_output("err_cycles", cap.cycles, 0);
    check_output("err_latency", cap_lat, 0);
    check_output("err_start_width", cap_start, 0);

    apply_stimulus(2'd0, 0, 1'b0, 2);
    check_output("to_cycles", cap.cycles, 100);
    check_output("to_flag", cap.timeout, 1);
    check_output("to_latency", cap_lat, 103);

    apply_stimulus(2'd2, 100, 1'b0, 0);
    check_output("edge_cycles", cap.cycles, 100);
    check_output("edge_timeout", cap.timeout, 0);

    apply_stimulus(2'd1, 1, 1'b1, 1);
    check_output("stale_cycles", cap.cycles, 1);

    reset_mid_run();
    apply_stimulus(2'd0, 7, 1'b0, 0);
    check_output("after_abort_cycles", cap.cycles, 7);

    for (int n = 0; n < 25; n++) begin
      int sel, dj;
      sel = $urandom_range(0, 9);
      if (sel == 0)      dj = 0;
      else if (sel == 1) dj = TO;
      else if (sel == 2) dj = TO + 1;
      else               dj = $urandom_range(1, TO - 1);
      apply_stimulus(2'($urandom_range(0, 3)), dj, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 4));
    end

    repeat (4) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
